draw_sprite_blit: RTL and testbench

//  Parametrised sprite blitter: copies a SPR_W x SPR_H image from an external synchronous
//  ROM to the frame-buffer write port at a run-time (x,y), one pixel per clock, fully pipelined.

---
 rtl/draw_pkg.sv | 22 ++
 rtl/draw_pipe_delay.sv | 30 +++
 rtl/draw_sprite_blit.sv | 175 +++++++++++++++++
 tb/tb_draw_sprite_blit.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared definitions for the sprite blit blocks: screen geometry, coordinate
// widths and the blitter FSM state encoding.
package draw_pkg;

  localparam int SCREEN_W    = 320;
  localparam int SCREEN_H    = 240;
  localparam int XP_W        = 10;  // signed sprite x position
  localparam int YP_W        = 9;   // signed sprite y position
  localparam int SX_W        = 11;  // signed screen x of a pixel
  localparam int SY_W        = 10;  // signed screen y of a pixel
  localparam int XO_W        = 9;   // frame-buffer x (0..319)
  localparam int YO_W        = 8;   // frame-buffer y (0..239)
  localparam int DEF_COLOR_W = 12;  // RGB444

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/draw_pipe_delay.sv
// Fixed-depth shift register carrying a valid bit plus side data alongside a
// synchronous memory read. Every stage is zeroed on reset or clear.
//  clk, reset : clock, synchronous active-high reset
//  clear      : synchronous flush of all stages
//  din / dout : stage input / output after DEPTH clocks
module draw_pipe_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/draw_sprite_blit.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite in a synchronous ROM, one
// pixel per clock, and emits frame-buffer writes with clipping, colour-key
// transparency and optional horizontal mirroring.
//  clk, reset            : clock, synchronous active-high reset
//  start, abort          : begin a draw (IDLE only) / cancel at next edge
//  flip_h, x_pos, y_pos  : draw parameters captured with start
//  rom_addr, rom_q       : sprite ROM port (data ROM_LAT clocks after addr)
//  X_out, Y_out, Color_out, writeEn : frame-buffer write port
//  busy, draw_done       : game FSM status / completion pulse
module draw_sprite_blit import draw_pkg::*; #(
  parameter int                 SPR_W     = 64,
  parameter int                 SPR_H     = 64,
  parameter int                 ADDR_W    = 12,
  parameter int                 COLOR_W   = DEF_COLOR_W,
  parameter int                 ROM_LAT   = 1,
  parameter logic [COLOR_W-1:0] KEY_COLOR = '0,
  parameter bit                 KEY_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               flip_h,
  input  logic [XP_W-1:0]    x_pos,
  input  logic [YP_W-1:0]    y_pos,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_q,
  output logic [XO_W-1:0]    X_out,
  output logic [YO_W-1:0]    Y_out,
  output logic [COLOR_W-1:0] Color_out,
  output logic               writeEn,
  output logic               busy,
  output logic               draw_done
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int DW    = 1 + SX_W + SY_W;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(SPR_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(SPR_W - 1);

  state_t state, state_nx;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_base;
  logic [2:0]        drain_cnt;
  logic              flip_r;
  logic [XP_W-1:0]   x_r;
  logic [YP_W-1:0]   y_r;
  logic              accept, issue, last_px;
  logic [SX_W-1:0]   sx, d_sx;
  logic [SY_W-1:0]   sy, d_sy;
  logic [DW-1:0]     dly_in, dly_out;
  logic              d_vld, in_screen, key_hit;

  // abort beats a simultaneous start
  assign accept  = (state == S_IDLE) && start && !abort;
  assign issue   = (state == S_RUN);
  assign last_px = issue && (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    draw_done = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last_px) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // ROM_LAT+1 cycles lets the last pixel clear ROM and output register
        if (drain_cnt == 3'(ROM_LAT)) state_nx = S_DONE;
      end
      S_DONE: begin
        draw_done = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // Counters return to zero after the last pixel or an abort, so IDLE always
  // starts the next sprite at pixel 0. Row base is accumulated, not multiplied.
  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      drain_cnt <= '0;
      flip_r    <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
    end else begin
      if (accept) begin
        x_r    <= x_pos;
        y_r    <= y_pos;
        flip_r <= flip_h;
      end
      if (abort) begin
        col      <= '0;
        row      <= '0;
        row_base <= '0;
      end else if (issue) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (row == ROW_LAST) begin
            row      <= '0;
            row_base <= '0;
          end else begin
            row      <= row + 1'b1;
            row_base <= row_base + ROW_STEP;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
    end
  end

  assign rom_addr = row_base + (flip_r ? COL_MAX - ADDR_W'(col) : ADDR_W'(col));

  // sign-extend position, zero-extend offset
  assign sx     = {x_r[XP_W-1], x_r} + SX_W'(col);
  assign sy     = {y_r[YP_W-1], y_r} + SY_W'(row);
  assign dly_in = {issue, sx, sy};

  draw_pipe_delay #(
    .DEPTH (ROM_LAT),
    .WIDTH (DW)
  ) u_dly (
    .clk   (clk),
    .reset (reset),
    .clear (abort),
    .din   (dly_in),
    .dout  (dly_out)
  );

  assign d_vld     = dly_out[DW-1];
  assign d_sx      = dly_out[DW-2 -: SX_W];
  assign d_sy      = dly_out[SY_W-1:0];
  assign in_screen = !d_sx[SX_W-1] && (d_sx < SX_W'(SCREEN_W)) &&
                     !d_sy[SY_W-1] && (d_sy < SY_W'(SCREEN_H));
  assign key_hit   = KEY_EN && (rom_q == KEY_COLOR);

  always_ff @(posedge clk) begin
    if (reset) begin
      X_out     <= '0;
      Y_out     <= '0;
      Color_out <= '0;
      writeEn   <= 1'b0;
    end else if (abort) begin
      writeEn <= 1'b0;
    end else begin
      writeEn <= d_vld && in_screen && !key_hit;
      if (d_vld) begin
        X_out     <= d_sx[XO_W-1:0];
        Y_out     <= d_sy[YO_W-1:0];
        Color_out <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_draw_sprite_blit.sv
// Bench for draw_sprite_blit: a 4x2 sprite on a ROM_LAT=1 keyed instance and a
// ROM_LAT=3 unkeyed instance driven in parallel. Expected writes are queued
// from a reference walk of the sprite and compared in order as they appear.
module tb_draw_sprite_blit;
  typedef logic [28:0] px_t;  // {x[8:0], y[7:0], colour[11:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0, abort = 1'b0, flip_h = 1'b0;
  logic [9:0] x_pos = '0;
  logic [8:0] y_pos = '0;
  logic [3:0] ra_a, ra_b;
  logic [11:0] rq_a, rq_b, rqb_p0, rqb_p1, ca, cb;
  logic [8:0] xa, xb;
  logic [7:0] ya, yb;
  logic wa, wb, ba, bb, da, db;
  logic [11:0] rom [0:7];

  function automatic logic [11:0] rd(input logic [3:0] a);
    return (a < 4'd8) ? rom[a[2:0]] : 12'hbad;
  endfunction

  always @(posedge clk) begin
    rq_a   <= rd(ra_a);
    rqb_p0 <= rd(ra_b);
    rqb_p1 <= rqb_p0;
    rq_b   <= rqb_p1;
  end

  draw_sprite_blit #(.SPR_W(4), .SPR_H(2), .ADDR_W(4), .COLOR_W(12), .ROM_LAT(1),
                     .KEY_COLOR(12'h000), .KEY_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .flip_h(flip_h),
    .x_pos(x_pos), .y_pos(y_pos), .rom_addr(ra_a), .rom_q(rq_a), .X_out(xa),
    .Y_out(ya), .Color_out(ca), .writeEn(wa), .busy(ba), .draw_done(da));

  draw_sprite_blit #(.SPR_W(4), .SPR_H(2), .ADDR_W(4), .COLOR_W(12), .ROM_LAT(3),
                     .KEY_COLOR(12'h000), .KEY_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .flip_h(flip_h),
    .x_pos(x_pos), .y_pos(y_pos), .rom_addr(ra_b), .rom_q(rq_b), .X_out(xb),
    .Y_out(yb), .Color_out(cb), .writeEn(wb), .busy(bb), .draw_done(db));

  int n_cmp = 0, n_bad = 0;
  px_t exp_q[$], obs_q[$];
  int cyc_q[$];
  int done_cyc, done_cnt;
  bit busy_tr [0:31];
  logic [35:0] snap;

  task automatic load_rom();
    for (int i = 0; i < 8; i++) rom[i] = 12'(i + 1);
  endtask

  // reference walk: push every pixel that must be written, in issue order
  task automatic push_exp(input int x, input int y, input bit fl, input bit key, input int lim);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        int idx, a, sx, sy;
        logic [11:0] colr;
        logic [31:0] ux, uy;
        idx = r * 4 + c;
        a = r * 4 + (fl ? 3 - c : c);
        sx = x + c;
        sy = y + r;
        colr = rom[a];
        ux = sx;
        uy = sy;
        if (idx < lim && sx >= 0 && sx < 320 && sy >= 0 && sy < 240 && !(key && colr == 12'h000))
          exp_q.push_back({ux[8:0], uy[7:0], colr});
      end
    end
  endtask

  // drive one draw from cycle 0 (start) and record 24 cycles of one DUT
  task automatic run_draw(input int sel, input int x, input int y, input bit fl,
                          input int abort_cyc, input int reset_cyc, input int busy_start_cyc);
    logic [31:0] ux, uy;
    ux = x;
    uy = y;
    obs_q.delete();
    cyc_q.delete();
    done_cyc = -1;
    done_cnt = 0;
    snap = '1;
    x_pos = ux[9:0];
    y_pos = uy[8:0];
    flip_h = fl;
    start = 1'b1;
    abort = (abort_cyc == 0);
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      #1;
      start = (c == busy_start_cyc);
      if (c == busy_start_cyc) x_pos = x_pos + 10'd50;
      abort = (c == abort_cyc);
      reset = (c == reset_cyc);
      if (sel == 0) begin
        if (wa) begin obs_q.push_back({xa, ya, ca}); cyc_q.push_back(c); end
        if (da) begin done_cnt++; done_cyc = c; end
        busy_tr[c] = ba;
      end else begin
        if (wb) begin obs_q.push_back({xb, yb, cb}); cyc_q.push_back(c); end
        if (db) begin done_cnt++; done_cyc = c; end
        busy_tr[c] = bb;
      end
      if (c == reset_cyc + 1) snap = {wa, ba, da, xa, ya, ca, ra_a};
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({wa, ba, da, xa, ya, ca, ra_a} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_a got %h exp 0", {wa, ba, da, xa, ya, ca, ra_a});
    end
    n_cmp++;
    if ({wb, bb, db, xb, yb, cb, ra_b} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_b got %h exp 0", {wb, bb, db, xb, yb, cb, ra_b});
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    load_rom();
    push_exp(10, 20, 1'b0, 1'b1, 8);
    run_draw(0, 10, 20, 1'b0, -1, -1, -1);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL basic_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < cyc_q.size(); i++) begin
      n_cmp++;
      if (cyc_q[i] != 3 + i) begin n_bad++; $display("FAIL basic_cycle got %0d exp %0d", cyc_q[i], 3 + i); end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      px_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL basic_px got %h exp %h", o, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (done_cyc != 11 || done_cnt != 1) begin
      n_bad++; $display("FAIL basic_done got cyc %0d cnt %0d exp 11/1", done_cyc, done_cnt);
    end
    n_cmp++;
    if (busy_tr[1] !== 1'b1 || busy_tr[12] !== 1'b0) begin
      n_bad++; $display("FAIL basic_busy got %b%b exp 10", busy_tr[1], busy_tr[12]);
    end
  endtask

  task automatic test_colour_key();
    load_rom();
    rom[2] = 12'h000;
    rom[5] = 12'h000;
    push_exp(10, 20, 1'b0, 1'b1, 8);
    run_draw(0, 10, 20, 1'b0, -1, -1, -1);
    n_cmp++;
    if (obs_q.size() != 6) begin n_bad++; $display("FAIL key_count got %0d exp 6", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      px_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL key_px got %h exp %h", o, e); end
    end
    exp_q.delete();
    load_rom();
  endtask

  task automatic test_clip();
    int tx[4] = '{-2, 318, 400, 0};
    int ty[4] = '{238, 100, 0, -1};
    int tn[4] = '{4, 4, 0, 4};
    load_rom();
    for (int t = 0; t < 4; t++) begin
      push_exp(tx[t], ty[t], 1'b0, 1'b1, 8);
      run_draw(0, tx[t], ty[t], 1'b0, -1, -1, -1);
      n_cmp++;
      if (obs_q.size() != tn[t]) begin
        n_bad++; $display("FAIL clip_count[%0d] got %0d exp %0d", t, obs_q.size(), tn[t]);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        px_t e, o;
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL clip_px[%0d] got %h exp %h", t, o, e); end
      end
      exp_q.delete();
      n_cmp++;
      if (done_cyc != 11) begin n_bad++; $display("FAIL clip_done[%0d] got %0d exp 11", t, done_cyc); end
    end
  endtask

  task automatic test_flip();
    load_rom();
    push_exp(0, 0, 1'b1, 1'b1, 8);
    run_draw(0, 0, 0, 1'b1, -1, -1, -1);
    n_cmp++;
    if (obs_q.size() != 8) begin n_bad++; $display("FAIL flip_count got %0d exp 8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      px_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL flip_px got %h exp %h", o, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_latency();
    load_rom();
    push_exp(10, 20, 1'b0, 1'b0, 8);
    run_draw(1, 10, 20, 1'b0, -1, -1, -1);
    n_cmp++;
    if (obs_q.size() != 8 || cyc_q.size() == 0 || cyc_q[0] != 5) begin
      n_bad++; $display("FAIL lat3_count got %0d writes exp 8 from cycle 5", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      px_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL lat3_px got %h exp %h", o, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (done_cyc != 13) begin n_bad++; $display("FAIL lat3_done got %0d exp 13", done_cyc); end
  endtask

  task automatic test_abort();
    load_rom();
    // abort in cycle 4: pixels 0 and 1 already reached the output register
    push_exp(10, 20, 1'b0, 1'b1, 2);
    run_draw(0, 10, 20, 1'b0, 4, -1, -1);
    n_cmp++;
    if (obs_q.size() != 2) begin n_bad++; $display("FAIL abort_count got %0d exp 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      px_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL abort_px got %h exp %h", o, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (done_cnt != 0 || busy_tr[5] !== 1'b0) begin
      n_bad++; $display("FAIL abort_state got done %0d busy %b exp 0/0", done_cnt, busy_tr[5]);
    end
    // start and abort together in IDLE
    run_draw(0, 10, 20, 1'b0, 0, -1, -1);
    n_cmp++;
    if (obs_q.size() != 0 || done_cnt != 0 || busy_tr[1] !== 1'b0) begin
      n_bad++; $display("FAIL start_abort got writes %0d done %0d busy %b exp 0/0/0",
                        obs_q.size(), done_cnt, busy_tr[1]);
    end
  endtask

  task automatic test_reset_mid();
    load_rom();
    push_exp(10, 20, 1'b0, 1'b1, 1);
    run_draw(0, 10, 20, 1'b0, -1, 3, -1);
    n_cmp++;
    if (obs_q.size() != 1) begin n_bad++; $display("FAIL rstmid_count got %0d exp 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      px_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL rstmid_px got %h exp %h", o, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (snap !== 36'd0) begin n_bad++; $display("FAIL rstmid_outputs got %h exp 0", snap); end
    n_cmp++;
    if (done_cnt != 0) begin n_bad++; $display("FAIL rstmid_done got %0d exp 0", done_cnt); end
  endtask

  task automatic test_back_to_back();
    load_rom();
    push_exp(10, 20, 1'b0, 1'b1, 8);
    run_draw(0, 10, 20, 1'b0, -1, -1, 3);
    n_cmp++;
    if (obs_q.size() != 8) begin n_bad++; $display("FAIL busy_start_count got %0d exp 8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      px_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL busy_start_px got %h exp %h", o, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (done_cnt != 1 || done_cyc != 11) begin
      n_bad++; $display("FAIL busy_start_done got cnt %0d cyc %0d exp 1/11", done_cnt, done_cyc);
    end
    // a fresh draw right after the previous one at a new place
    push_exp(100, 50, 1'b1, 1'b1, 8);
    run_draw(0, 100, 50, 1'b1, -1, -1, -1);
    n_cmp++;
    if (obs_q.size() != 8 || done_cyc != 11) begin
      n_bad++; $display("FAIL b2b_second got %0d writes done %0d exp 8/11", obs_q.size(), done_cyc);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      px_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL b2b_px got %h exp %h", o, e); end
    end
    exp_q.delete();
  endtask

  initial begin
    load_rom();
    test_reset();
    test_basic();
    test_colour_key();
    test_clip();
    test_flip();
    test_latency();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
